// File: rtl/regfile_scoreboard.sv
// 2**ADDR_W x DATA_W register file with a per-register pending scoreboard for decode stalls.
// Optional macro REGFILE_WB_BYPASS_EN forwards same-cycle write-back data to the read ports.
`timescale 1ns/1ps

module regfile_scoreboard #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic              rs_busy,
    output logic              rt_busy,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic [ADDR_W:0]   pend_cnt
);

    localparam int NREGS = 2**ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  pend;
    logic              wr_ok;
    logic              iss_ok;
    logic              cnt_inc;
    logic              cnt_dec;

    assign wr_ok  = wr_en  && (wr_addr  != '0);
    assign iss_ok = iss_en && (iss_addr != '0);

    // A clear is cancelled when a newer issue lands on the same register this cycle.
    assign cnt_inc = iss_ok && !pend[iss_addr];
    assign cnt_dec = wr_ok && pend[wr_addr] && !(iss_ok && (iss_addr == wr_addr));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // The issue assignment comes last so it overrides a same-address clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            if (wr_ok) begin
                pend[wr_addr] <= 1'b0;
            end
            if (iss_ok) begin
                pend[iss_addr] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_cnt <= '0;
        end else if (cnt_inc && !cnt_dec) begin
            pend_cnt <= pend_cnt + {{ADDR_W{1'b0}}, 1'b1};
        end else if (cnt_dec && !cnt_inc) begin
            pend_cnt <= pend_cnt - {{ADDR_W{1'b0}}, 1'b1};
        end
    end

`ifdef REGFILE_WB_BYPASS_EN
    logic rs_hit;
    logic rt_hit;

    assign rs_hit = wr_ok && (wr_addr == rs_addr);
    assign rt_hit = wr_ok && (wr_addr == rt_addr);

    always_comb begin
        rs_data = regs[rs_addr];
        rt_data = regs[rt_addr];
        rs_busy = pend[rs_addr];
        rt_busy = pend[rt_addr];
        if (rs_hit) begin
            rs_data = wr_data;
            if (!(iss_ok && (iss_addr == rs_addr))) begin
                rs_busy = 1'b0;
            end
        end
        if (rt_hit) begin
            rt_data = wr_data;
            if (!(iss_ok && (iss_addr == rt_addr))) begin
                rt_busy = 1'b0;
            end
        end
    end
`else
    always_comb begin
        rs_data = regs[rs_addr];
        rt_data = regs[rt_addr];
        rs_busy = pend[rs_addr];
        rt_busy = pend[rt_addr];
    end
`endif

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

- 32 x 32-bit general register file with two combinational read ports and one synchronous write port.
- Adds a per-register pending scoreboard.
- Sits directly downstream of the write-back 3:1 select: that selector's 32-bit output drives `wr_data` here.
- The scoreboard lets the decode stage stall on registers whose write-back has not landed yet.

## Interface

Parameters:
- `DATA_W`, 32: register width.
- `ADDR_W`, 5: register index width; register count is 2**ADDR_W.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `rs_addr`  input  ADDR_W  read port A index.
- `rt_addr`  input  ADDR_W  read port B index.
- `rs_data`  output  DATA_W  read port A data (combinational).
- `rt_data`  output  DATA_W  read port B data (combinational).
- `rs_busy`  output  1  read port A register is pending.
- `rt_busy`  output  1  read port B register is pending.
- `wr_en`  input  1  write-back strobe.
- `wr_addr`  input  ADDR_W  write-back destination.
- `wr_data`  input  DATA_W  write-back value (from write-back select).
- `iss_en`  input  1  issue strobe: the destination will be written later.
- `iss_addr`  input  ADDR_W  issued destination index.
- `pend_cnt`  output  ADDR_W+1  number of registers currently pending.

## Operation

Register 0:
- Reads return 0.
- Writes are ignored.
- Issue is ignored; it is never pending and `rs_busy`/`rt_busy` are 0 for it.

Write:
- On a rising edge with `wr_en=1` and `wr_addr!=0`, `regs[wr_addr] <= wr_data` and `pend[wr_addr] <= 0`.

Issue:
- On a rising edge with `iss_en=1` and `iss_addr!=0`, `pend[iss_addr] <= 1`.

Simultaneous write and issue:
- Same nonzero address: issue wins. Data is written, but the pending bit stays or becomes 1, because the newer producer is outstanding.
- Different addresses: both take effect independently.

Other pending-bit rules:
- Issue to an already-pending register: the bit stays 1 and `pend_cnt` is unchanged.
- Write to a non-pending register: data is written and `pend_cnt` is unchanged (legal, e.g. an untracked producer).

`pend_cnt` is the registered population count of `pend`:
- Increments by 1 on the edge when a bit goes 0->1.
- Decrements by 1 on the edge when a bit goes 1->0.
- Unchanged when both happen in one cycle.
- Never wraps: maximum 2**ADDR_W-1 (31), minimum 0.

Read ports:
- `rs_data = regs[rs_addr]`, `rt_data = regs[rt_addr]`.
- `rs_busy = pend[rs_addr]`, `rt_busy = pend[rt_addr]`.
- Both ports may address the same register.

## Timing

- Reads are zero latency, combinational from the address and current state.
- A write becomes visible on the read ports the cycle after `wr_en`, unless bypass is enabled (see Configuration).
- Issue becomes visible on `*_busy` the cycle after `iss_en`.
- `pend_cnt` updates on the same edge as the `pend` bits.

Reset (`rst_n=0`, asynchronous):
- All registers are 0, all `pend` bits are 0, and `pend_cnt` is 0.
- Therefore all read data and busy outputs are 0.
- Reset asserted mid-operation clears everything immediately, regardless of `clk`; in-flight writes and issues are discarded.
- Reset deassertion takes effect on the next rising edge.

## Configuration

`REGFILE_WB_BYPASS_EN`:
- Defined: when `wr_en=1`, `wr_addr!=0` and `wr_addr` equals a read address, that port returns `wr_data` in the same cycle.
- Defined: that port's busy output reads 0 in the same cycle, unless `iss_en` targets the same address in that cycle, in which case busy stays at the registered value.
- Undefined: reads always reflect registered state. A same-cycle read of the address being written returns the old value and the old busy bit.

## Test plan

- Reset, then read all 32 indices on both ports: all data are 0, both busy outputs are 0, `pend_cnt`=0.
- Write r5=0xDEADBEEF, then read r5 on both ports next cycle: data 0xDEADBEEF, busy 0.
- Write r0=0xFFFFFFFF: r0 still reads 0.
- Issue r3, r7, r3: `pend_cnt` goes 1, 2, 2 and `rs_busy`(r3)=1.
- Then write r7=0x12: `pend_cnt`=1 and r7 busy=0.
- Same cycle, issue r9 and write r9=0xA5: next cycle r9 reads 0xA5, busy=1, `pend_cnt` increments by 1.
- Same cycle, write r4=0x55 while reading r4.
  - Without the macro: reads the old value 0 and old busy.
  - With `REGFILE_WB_BYPASS_EN`: reads 0x55 with busy 0.
- Issue r1..r31, then pulse `rst_n` low between clock edges: all outputs are 0 immediately.
- Issue r1..r31 without reset: `pend_cnt`=31.
- Write back all 31: `pend_cnt` returns to 0 without underflow.
